// File: rtl/alu_flag_accumulator_pkg.sv
// Shared types and default widths for the ALU flag accumulator.
//   acc_state_e : accumulator FSM states (StAccum, StHold)
//   alu_word_t  : upstream result word {zero_flag, field[1:0]}
package alu_acc_pkg;

    localparam int unsigned DefFrameLen = 8;
    localparam int unsigned DefSumW     = 6;
    localparam int unsigned DefCntW     = 4;

    typedef enum logic [0:0] {
        StAccum,
        StHold
    } acc_state_e;

    typedef struct packed {
        logic       zero_flag;
        logic [1:0] field;
    } alu_word_t;

endpackage

// File: rtl/alu_flag_accumulator_if.sv
// Stream interface for the ALU flag accumulator.
//   Input side : in_valid, in_ready, in_data[2:0] = {zero_flag, field}
//   Output side: out_valid, out_ready, out_sum, out_zero_cnt, out_err
//   master : environment view (drives words, accepts results)
//   slave  : accumulator view
interface alu_acc_if #(
    parameter int unsigned SUM_W = 6,
    parameter int unsigned CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic [CNT_W-1:0] out_zero_cnt;
    logic             out_err;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_zero_cnt, out_err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_zero_cnt, out_err
    );
endinterface

// File: rtl/alu_flag_accumulator_word_check.sv
// Combinational consistency check of one upstream word: the zero flag must
// be set exactly when the field is zero.
//   word_i         : {zero_flag, field}
//   inconsistent_o : 1 when flag and field disagree
module alu_word_check
    import alu_acc_pkg::*;
(
    input  alu_word_t word_i,
    output logic      inconsistent_o
);

    assign inconsistent_o = word_i.zero_flag != (word_i.field == 2'b00);

endmodule

// File: rtl/alu_flag_accumulator.sv
// Accumulates frames of FRAME_LEN upstream words and presents, per frame,
// the field sum, the zero-flag count and a sticky consistency error on a
// registered valid/ready output.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : alu_acc_if slave (input word stream + frame result stream)
// Build option: ALU_ACC_SATURATE_EN makes the running sum saturate at
// 2^SUM_W-1 instead of wrapping.
module alu_flag_accumulator
    import alu_acc_pkg::*;
#(
    parameter int unsigned FRAME_LEN = DefFrameLen,
    parameter int unsigned SUM_W     = DefSumW,
    parameter int unsigned CNT_W     = DefCntW
) (
    input logic     clk,
    input logic     rst,
    alu_acc_if.slave bus
);

    localparam int unsigned WcntW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [WcntW-1:0] LastIdx = WcntW'(FRAME_LEN - 1);

    acc_state_e       state_q;
    logic [SUM_W-1:0] sum_q,  sum_d;
    logic [CNT_W-1:0] zcnt_q, zcnt_d;
    logic             err_q,  err_d;
    logic [WcntW-1:0] wcnt_q;
    logic             out_valid_q;
    logic [SUM_W-1:0] out_sum_q;
    logic [CNT_W-1:0] out_zcnt_q;
    logic             out_err_q;

    alu_word_t        word;
    logic             inconsistent;
    logic             accept;
    logic [SUM_W:0]   sum_ext;

    assign word   = alu_word_t'(bus.in_data);
    assign accept = (state_q == StAccum) && bus.in_valid;

    alu_word_check u_word_check (
        .word_i         (word),
        .inconsistent_o (inconsistent)
    );

    // Running values including the current word; used both for the
    // accumulator update and for loading the final frame result.
    always_comb begin
        sum_ext = {1'b0, sum_q} + (SUM_W + 1)'(word.field);
`ifdef ALU_ACC_SATURATE_EN
        sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
`else
        sum_d = sum_ext[SUM_W-1:0];
`endif
        zcnt_d = zcnt_q + CNT_W'(word.zero_flag);
        err_d  = err_q | inconsistent;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StAccum;
            sum_q       <= '0;
            zcnt_q      <= '0;
            err_q       <= 1'b0;
            wcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_zcnt_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StAccum: begin
                    if (accept) begin
                        if (wcnt_q == LastIdx) begin
                            out_sum_q   <= sum_d;
                            out_zcnt_q  <= zcnt_d;
                            out_err_q   <= err_d;
                            out_valid_q <= 1'b1;
                            state_q     <= StHold;
                            sum_q       <= '0;
                            zcnt_q      <= '0;
                            err_q       <= 1'b0;
                            wcnt_q      <= '0;
                        end else begin
                            sum_q  <= sum_d;
                            zcnt_q <= zcnt_d;
                            err_q  <= err_d;
                            wcnt_q <= wcnt_q + WcntW'(1);
                        end
                    end
                end
                StHold: begin
                    // out_valid is always set in this state
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StAccum;
                    end
                end
                default: state_q <= StAccum;
            endcase
        end
    end

    assign bus.in_ready     = (state_q == StAccum);
    assign bus.out_valid    = out_valid_q;
    assign bus.out_sum      = out_sum_q;
    assign bus.out_zero_cnt = out_zcnt_q;
    assign bus.out_err      = out_err_q;

endmodule

// File: tb/tb_alu_flag_accumulator.sv
// Self-checking bench for alu_flag_accumulator: directed and random frames
// against a frame-level reference model, plus a narrow-sum instance for the
// wrap/saturate boundary.
module tb_alu_flag_accumulator;
    import alu_acc_pkg::*;

    localparam int FL = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_acc_if #(.SUM_W(6), .CNT_W(4)) bus6 ();
    alu_acc_if #(.SUM_W(4), .CNT_W(4)) bus4 ();

    alu_flag_accumulator #(.FRAME_LEN(FL), .SUM_W(6), .CNT_W(4)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6)
    );

    alu_flag_accumulator #(.FRAME_LEN(FL), .SUM_W(4), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    int checks = 0;
    int errors = 0;
    logic [2:0] frame_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: frame results from the list of accepted words.
    function automatic int model_sum(input int w);
        int total = 0;
        int lim = (1 << w);
        foreach (frame_q[i]) total += int'(frame_q[i][1:0]);
`ifdef ALU_ACC_SATURATE_EN
        return (total > lim - 1) ? lim - 1 : total;
`else
        return total % lim;
`endif
    endfunction

    function automatic int model_zcnt();
        int n = 0;
        foreach (frame_q[i]) if (frame_q[i][2]) n++;
        return n;
    endfunction

    function automatic int model_err();
        int e = 0;
        foreach (frame_q[i]) if (frame_q[i][2] != (frame_q[i][1:0] == 2'd0)) e = 1;
        return e;
    endfunction

    function automatic logic [2:0] rand_clean();
        logic [1:0] f;
        f = 2'($urandom_range(3, 0));
        return {f == 2'd0, f};
    endfunction

    task automatic push(input logic [2:0] w, input int max_gap);
        int gap;
        int n;
        gap = $urandom_range(max_gap, 0);
        bus6.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus6.in_valid = 1'b1;
        bus6.in_data  = w;
        n = 0;
        while (!bus6.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("push_in_ready", 32'(bus6.in_ready), 32'd1);
        @(negedge clk);
        bus6.in_valid = 1'b0;
        frame_q.push_back(w);
    endtask

    task automatic run_frame(input logic [2:0] words[FL], input int max_gap, input string tag);
        frame_q.delete();
        for (int i = 0; i < FL; i++) begin
            push(words[i], max_gap);
            if (i < FL - 1) chk({tag, "_early_valid"}, 32'(bus6.out_valid), 32'd0);
        end
        chk({tag, "_out_valid"}, 32'(bus6.out_valid), 32'd1);
        chk({tag, "_in_ready_low"}, 32'(bus6.in_ready), 32'd0);
        chk({tag, "_sum"}, 32'(bus6.out_sum), 32'(model_sum(6)));
        chk({tag, "_zcnt"}, 32'(bus6.out_zero_cnt), 32'(model_zcnt()));
        chk({tag, "_err"}, 32'(bus6.out_err), 32'(model_err()));
    endtask

    task automatic handshake(input string tag);
        bus6.out_ready = 1'b1;
        @(negedge clk);
        bus6.out_ready = 1'b0;
        chk({tag, "_hs_valid_clr"}, 32'(bus6.out_valid), 32'd0);
        chk({tag, "_hs_in_ready"}, 32'(bus6.in_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] words[FL];
        logic [5:0] held_sum;
        logic [3:0] held_zcnt;
        logic       held_err;
        int         exp4;

        rst = 1'b1;
        bus6.in_valid = 1'b0; bus6.in_data = 3'b000; bus6.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_data = 3'b000; bus4.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus6.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus6.out_valid), 32'd0);
        chk("rst_sum", 32'(bus6.out_sum), 32'd0);
        chk("rst_zcnt", 32'(bus6.out_zero_cnt), 32'd0);
        chk("rst_err", 32'(bus6.out_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // All-zero words, back to back
        words = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
        run_frame(words, 0, "zeros");
        chk("zeros_zcnt_const", 32'(bus6.out_zero_cnt), 32'd8);
        handshake("zeros");

        // Nonzero fields with random gaps
        words = '{3'b001, 3'b010, 3'b011, 3'b001, 3'b010, 3'b011, 3'b001, 3'b010};
        run_frame(words, 3, "fields");
        chk("fields_sum_const", 32'(bus6.out_sum), 32'd15);
        handshake("fields");

        // Reset mid-frame discards the partial frame and clears outputs
        frame_q.delete();
        for (int i = 0; i < 3; i++) push(3'b011, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(bus6.in_ready), 32'd1);
        chk("mid_rst_valid", 32'(bus6.out_valid), 32'd0);
        chk("mid_rst_sum", 32'(bus6.out_sum), 32'd0);
        chk("mid_rst_zcnt", 32'(bus6.out_zero_cnt), 32'd0);
        chk("mid_rst_err", 32'(bus6.out_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < FL; i++) words[i] = rand_clean();
        run_frame(words, 2, "post_rst");
        handshake("post_rst");

        // Downstream stall with upstream valid held: nothing consumed
        for (int i = 0; i < FL; i++) words[i] = 3'($urandom_range(7, 0));
        run_frame(words, 1, "stall");
        held_sum  = bus6.out_sum;
        held_zcnt = bus6.out_zero_cnt;
        held_err  = bus6.out_err;
        bus6.in_valid = 1'b1;
        bus6.in_data  = 3'b011;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus6.out_valid), 32'd1);
            chk("stall_in_ready", 32'(bus6.in_ready), 32'd0);
            chk("stall_sum", 32'(bus6.out_sum), 32'(held_sum));
            chk("stall_zcnt", 32'(bus6.out_zero_cnt), 32'(held_zcnt));
            chk("stall_err", 32'(bus6.out_err), 32'(held_err));
        end
        bus6.out_ready = 1'b1;
        @(negedge clk);
        bus6.in_valid  = 1'b0;
        bus6.out_ready = 1'b0;
        chk("stall_hs_valid_clr", 32'(bus6.out_valid), 32'd0);
        chk("stall_hs_in_ready", 32'(bus6.in_ready), 32'd1);
        for (int i = 0; i < FL; i++) words[i] = rand_clean();
        run_frame(words, 0, "after_stall");
        handshake("after_stall");

        // One inconsistent word, then a clean frame
        words = '{3'b100, 3'b001, 3'b010, 3'b101, 3'b011, 3'b100, 3'b001, 3'b010};
        run_frame(words, 1, "err");
        chk("err_const", 32'(bus6.out_err), 32'd1);
        handshake("err");
        for (int i = 0; i < FL; i++) words[i] = rand_clean();
        run_frame(words, 1, "clean");
        chk("clean_err_const", 32'(bus6.out_err), 32'd0);
        handshake("clean");

        // Random frames with random handshake delay
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < FL; i++) words[i] = 3'($urandom_range(7, 0));
            run_frame(words, 2, "rand");
            repeat ($urandom_range(3, 0)) @(negedge clk);
            chk("rand_hold_valid", 32'(bus6.out_valid), 32'd1);
            handshake("rand");
        end

        // Narrow sum: 8 x field 3 = 24 overflows 4 bits
        bus4.in_valid = 1'b1;
        bus4.in_data  = 3'b011;
        repeat (FL) @(negedge clk);
        bus4.in_valid = 1'b0;
`ifdef ALU_ACC_SATURATE_EN
        exp4 = 15;
`else
        exp4 = 24 % 16;
`endif
        chk("w4_valid", 32'(bus4.out_valid), 32'd1);
        chk("w4_sum", 32'(bus4.out_sum), 32'(exp4));
        chk("w4_zcnt", 32'(bus4.out_zero_cnt), 32'd0);
        chk("w4_err", 32'(bus4.out_err), 32'd0);
        bus4.out_ready = 1'b1;
        @(negedge clk);
        bus4.out_ready = 1'b0;
        chk("w4_hs_valid_clr", 32'(bus4.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
